game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl.sv | 109 ++++++++++
 tb/tb_game_timer_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// Countdown game controller: drives load/tick/run strobes of a 3-digit BCD down
// counter, reports expiry, low-time warning with blink phase, and elapsed seconds.
module game_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int WARN_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] countH,
    input  logic [3:0] countM,
    input  logic [3:0] countL,
    input  logic       tc_in,
    output logic       loadN,
    output logic       enable1,
    output logic       enable2,
    output logic       game_over,
    output logic       warning,
    output logic       blink,
    output logic [9:0] secs_elapsed
);

    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF   = PW'(TICK_DIV / 2);
    localparam logic [10:0]   WARN_V = 11'(WARN_SEC);
    localparam logic [9:0]    SECS_MAX = 10'd1023;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSE,
        OVER
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [9:0]    secs;
    logic [10:0]   value;
    logic          tick;
    logic          live;

    // Tick is suppressed when the counter already reports terminal count.
    assign tick = (state == RUN) && (presc == LAST) && !tc_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            presc <= '0;
            secs  <= '0;
        end else begin
            if (tick && (secs != SECS_MAX))
                secs <= secs + 10'd1;
            case (state)
                IDLE: begin
                    if (start)
                        state <= LOAD;
                end
                LOAD: begin
                    presc <= '0;
                    secs  <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (start) begin
                        state <= LOAD;
                    end else if (tc_in) begin
                        state <= OVER;
                    end else begin
                        // The pause cycle still counts; the value is frozen from PAUSE on.
                        presc <= (presc == LAST) ? '0 : presc + PW'(1);
                        if (pause)
                            state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start)
                        state <= LOAD;
                    else if (pause && !tc_in)
                        state <= RUN;
                end
                OVER: begin
                    if (start)
                        state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so they are quiet even before the first reset edge.
    assign live = !reset;

    assign value = ({7'd0, countH} * 11'd100)
                 + ({7'd0, countM} * 11'd10)
                 + {7'd0, countL};

    assign loadN        = !(live && (state == LOAD));
    assign enable1      = live && tick;
    assign enable2      = live && (state == RUN);
    assign game_over    = live && (state == OVER);
    assign warning      = live && ((state == RUN) || (state == PAUSE))
                          && (value < WARN_V) && !tc_in;
    assign blink        = warning && (presc >= HALF);
    assign secs_elapsed = secs;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomised + directed bench for game_timer_ctrl; a behavioural model pushes
// expected outputs per cycle and a negedge monitor pops and compares them.
module tb_game_timer_ctrl;

    localparam int TD = 4;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       reset, start, pause, tc_in;
    logic [3:0] countH, countM, countL;
    logic       loadN, enable1, enable2, game_over, warning, blink;
    logic [9:0] secs_elapsed;

    game_timer_ctrl #(.TICK_DIV(TD), .WARN_SEC(WS)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .countH(countH), .countM(countM), .countL(countL), .tc_in(tc_in),
        .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .game_over(game_over), .warning(warning), .blink(blink),
        .secs_elapsed(secs_elapsed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       loadN;
        logic       en1;
        logic       en2;
        logic       over;
        logic       warn;
        logic       blink;
        logic [9:0] secs;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   active = 0;

    // Behavioural model: game mode, position within the current second, seconds count.
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_OVER} mode_t;
    mode_t mode;
    int    ph;
    int    secs_m;
    int    ch, cm, cl;

    task automatic step(input logic r, input logic s, input logic p, input logic tc);
        obs_t e;
        int   v;
        bit   tk;
        reset  = r;
        start  = s;
        pause  = p;
        tc_in  = tc;
        countH = 4'(ch);
        countM = 4'(cm);
        countL = 4'(cl);
        v  = ch * 100 + cm * 10 + cl;
        tk = !r && mode == M_RUN && ph == TD - 1 && !tc;
        e.loadN = r || mode != M_LOAD;
        e.en1   = tk;
        e.en2   = !r && mode == M_RUN;
        e.over  = !r && mode == M_OVER;
        e.warn  = !r && (mode == M_RUN || mode == M_PAUSE) && v < WS && !tc;
        e.blink = e.warn && ph >= TD / 2;
        e.secs  = 10'(secs_m);
        exp_q.push_back(e);
        active = 1;
        if (r) begin
            mode = M_IDLE; ph = 0; secs_m = 0;
        end else begin
            if (tk) secs_m = (secs_m < 1023) ? secs_m + 1 : 1023;
            case (mode)
                M_IDLE:  if (s) mode = M_LOAD;
                M_LOAD:  begin mode = M_RUN; ph = 0; secs_m = 0; end
                M_RUN: begin
                    if (s) mode = M_LOAD;
                    else if (tc) mode = M_OVER;
                    else begin
                        ph = (ph + 1) % TD;
                        if (p) mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (s) mode = M_LOAD; else if (p && !tc) mode = M_RUN;
                M_OVER:  if (s) mode = M_LOAD;
                default: mode = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < TD + 2 && !(mode == M_RUN && ph == target); i++)
            step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic counts(input int h, input int m, input int l);
        ch = h; cm = m; cl = l;
    endtask

    always @(negedge clk) begin
        obs_t e, g;
        if (active) begin
            g = {loadN, enable1, enable2, game_over, warning, blink, secs_elapsed};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t no expected entry for observed outputs", $time);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got loadN=%b en1=%b en2=%b over=%b warn=%b blink=%b secs=%0d want loadN=%b en1=%b en2=%b over=%b warn=%b blink=%b secs=%0d",
                             $time, g.loadN, g.en1, g.en2, g.over, g.warn, g.blink, g.secs,
                             e.loadN, e.en1, e.en2, e.over, e.warn, e.blink, e.secs);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; tc_in = 1'b0;
        counts(5, 5, 5);
        countH = 4'd5; countM = 4'd5; countL = 4'd5;
        mode = M_IDLE; ph = 0; secs_m = 0;
        @(posedge clk);
        #1;

        // Reset state, and IDLE ignoring everything but start
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Basic run
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14);

        // Expiry with tc coincident with the last prescaler phase
        counts(0, 0, 1);
        run_to(TD - 1);
        counts(0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Pause / resume
        counts(4, 2, 7);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        run_to(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        // Warning / blink thresholds
        counts(0, 0, 2); idle(8);
        counts(0, 0, 3); idle(4);
        counts(0, 0, 0); idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Simultaneous events
        counts(1, 0, 0);
        run_to(1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // Saturation, then reset mid-RUN and during LOAD
        counts(9, 9, 9);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4500);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s, p, t;
            if ($urandom_range(0, 3) == 0) counts(0, 0, $urandom_range(0, 5));
            else if ($urandom_range(0, 30) == 0) counts($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) counts($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 29) == 0);
            p = ($urandom_range(0, 14) == 0);
            t = ($urandom_range(0, 19) == 0);
            step(r, s, p, t);
        end

        active = 0;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
